// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter and refresh scheduler for a single-port 4K x 8 dram.
// Each access is one IDLE->ACCESS->IDLE round trip; refresh windows block all grants.
module dram_arbiter #(
    parameter int ADDR_W           = 12,
    parameter int DATA_W           = 8,
    parameter int REFRESH_INTERVAL = 512,
    parameter int REFRESH_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_0,
    input  logic              req_1,
    input  logic              we_0,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_0,
    output logic              gnt_1,
    output logic              rvalid_0,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_0,
    output logic [DATA_W-1:0] rdata_1,
    output logic              refresh_busy,
    output logic [15:0]       refresh_count,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_data_out
);
    localparam int IW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int WW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        REFRESH = 2'd2
    } state_t;

    state_t              state_reg;
    logic [IW-1:0]       interval_reg;
    logic                refresh_pending_reg;
    logic [WW-1:0]       window_reg;
    logic                last_grant_reg;
    logic                port_reg;
    logic [1:0]          gnt_reg;
    logic                busy_reg;
    logic [15:0]         count_reg;
    logic [ADDR_W-1:0]   mem_address_reg;
    logic [DATA_W-1:0]   mem_data_in_reg;
    logic                mem_we_reg;

    logic [ADDR_W-1:0]   addr_arr [2];
    logic [DATA_W-1:0]   wdata_arr [2];
    logic [1:0]          we_vec;
    logic                win_valid;
    logic                win_port;
    logic                interval_wrap;
    logic                read_done;

    assign addr_arr[0]  = addr_0;
    assign addr_arr[1]  = addr_1;
    assign wdata_arr[0] = wdata_0;
    assign wdata_arr[1] = wdata_1;
    assign we_vec       = {we_1, we_0};

    // A lone request always wins; on a tie the port that did not win last time goes.
    assign win_valid = req_0 | req_1;
    always_comb begin
        win_port = req_1;
        if (req_0 && req_1) begin
            win_port = ~last_grant_reg;
        end
    end

    assign interval_wrap = (interval_reg == IW'(REFRESH_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            interval_reg        <= '0;
            refresh_pending_reg <= 1'b0;
            window_reg          <= '0;
            last_grant_reg      <= 1'b1;
            port_reg            <= 1'b0;
            gnt_reg             <= '0;
            busy_reg            <= 1'b0;
            count_reg           <= '0;
            mem_address_reg     <= '0;
            mem_data_in_reg     <= '0;
            mem_we_reg          <= 1'b0;
        end else begin
            interval_reg <= interval_wrap ? '0 : interval_reg + 1'b1;
            gnt_reg      <= '0;
            mem_we_reg   <= 1'b0;

            unique case (state_reg)
                IDLE: begin
                    if (refresh_pending_reg) begin
                        state_reg           <= REFRESH;
                        refresh_pending_reg <= 1'b0;
                        window_reg          <= WW'(REFRESH_CYCLES - 1);
                        busy_reg            <= 1'b1;
                    end else if (win_valid) begin
                        state_reg         <= ACCESS;
                        mem_address_reg   <= addr_arr[win_port];
                        mem_data_in_reg   <= wdata_arr[win_port];
                        mem_we_reg        <= we_vec[win_port];
                        gnt_reg[win_port] <= 1'b1;
                        last_grant_reg    <= win_port;
                        port_reg          <= win_port;
                    end
                end
                ACCESS: begin
                    state_reg <= IDLE;
                end
                REFRESH: begin
                    if (window_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= count_reg + 16'd1;
                    end else begin
                        window_reg <= window_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Placed after the FSM so a wrap on the same edge as a clear is never lost.
            if (interval_wrap) begin
                refresh_pending_reg <= 1'b1;
            end
        end
    end

    // A read completes on the edge that ends ACCESS; the dram output is live then.
    assign read_done = (state_reg == ACCESS) && !mem_we_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic              rvalid_q;
        logic [DATA_W-1:0] rdata_q;
        logic              hit;

        assign hit = read_done && (port_reg == 1'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= hit;
                if (hit) begin
                    rdata_q <= mem_data_out;
                end
            end
        end
    end

    assign gnt_0         = gnt_reg[0];
    assign gnt_1         = gnt_reg[1];
    assign rvalid_0      = g_rd[0].rvalid_q;
    assign rvalid_1      = g_rd[1].rvalid_q;
    assign rdata_0       = g_rd[0].rdata_q;
    assign rdata_1       = g_rd[1].rdata_q;
    assign refresh_busy  = busy_reg;
    assign refresh_count = count_reg;
    assign mem_address   = mem_address_reg;
    assign mem_data_in   = mem_data_in_reg;
    assign mem_we        = mem_we_reg;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random two-port traffic, all outputs
// checked every cycle against a transaction-level model with its own copy of memory.
module tb_dram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int RI = 64;
    localparam int RC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_0 = 1'b0, req_1 = 1'b0;
    logic          we_0 = 1'b0, we_1 = 1'b0;
    logic [AW-1:0] addr_0 = '0, addr_1 = '0;
    logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          refresh_busy;
    logic [15:0]   refresh_count;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_we;
    logic [DW-1:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
        .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .refresh_busy(refresh_busy), .refresh_count(refresh_count),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_we(mem_we),
        .mem_data_out(mem_data_out)
    );

    // dram stand-in: combinational read, undriven while writing, write on the rising edge
    logic [DW-1:0] dram [4096];
    logic [DW-1:0] ref_mem [4096];
    assign mem_data_out = mem_we ? 8'hxx : dram[mem_address];
    always @(posedge clk) if (mem_we) dram[mem_address] <= mem_data_in;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            dram[i]    <= v;
            ref_mem[i] = v;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit            m_on = 0;
    int            m_tick, m_ref_left;
    bit            m_pend, m_last, m_acc, m_acc_port, m_acc_we;
    logic [AW-1:0] m_acc_addr;
    logic [DW-1:0] m_acc_data;
    logic [1:0]    e_gnt, e_rvalid;
    logic [DW-1:0] e_rdata [2];
    bit            e_busy, e_we;
    logic [15:0]   e_count;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    task automatic model_step();
        bit wrap;
        bit w;
        e_gnt    = '0;
        e_rvalid = '0;
        if (rst) begin
            if (m_acc && m_acc_we) ref_mem[m_acc_addr] = m_acc_data;
            m_on = 1; m_tick = 0; m_pend = 0; m_ref_left = 0; m_last = 1; m_acc = 0;
            e_rdata[0] = '0; e_rdata[1] = '0;
            e_busy = 0; e_count = '0; e_addr = '0; e_wdata = '0; e_we = 0;
        end else if (m_on) begin
            wrap   = (m_tick == RI - 1);
            m_tick = wrap ? 0 : m_tick + 1;
            if (m_acc) begin
                if (m_acc_we) ref_mem[m_acc_addr] = m_acc_data;
                else begin
                    e_rvalid[m_acc_port] = 1'b1;
                    e_rdata[m_acc_port]  = ref_mem[m_acc_addr];
                end
                m_acc = 0;
                e_we  = 0;
            end else if (m_ref_left > 0) begin
                m_ref_left--;
                if (m_ref_left == 0) begin
                    e_busy  = 0;
                    e_count = e_count + 16'd1;
                end
            end else if (m_pend) begin
                m_pend     = 0;
                m_ref_left = RC;
                e_busy     = 1;
            end else if (req_0 || req_1) begin
                w          = (req_0 && req_1) ? !m_last : req_1;
                m_acc      = 1;
                m_acc_port = w;
                m_acc_we   = w ? we_1 : we_0;
                m_acc_addr = w ? addr_1 : addr_0;
                m_acc_data = w ? wdata_1 : wdata_0;
                e_gnt[w]   = 1'b1;
                e_addr     = m_acc_addr;
                e_wdata    = m_acc_data;
                e_we       = m_acc_we;
                m_last     = w;
            end
            if (wrap) m_pend = 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_on) begin
            check("gnt_0", gnt_0, e_gnt[0]);
            check("gnt_1", gnt_1, e_gnt[1]);
            check("rvalid_0", rvalid_0, e_rvalid[0]);
            check("rvalid_1", rvalid_1, e_rvalid[1]);
            check("rdata_0", rdata_0, e_rdata[0]);
            check("rdata_1", rdata_1, e_rdata[1]);
            check("refresh_busy", refresh_busy, e_busy);
            check("refresh_count", refresh_count, e_count);
            check("mem_we", mem_we, e_we);
            if (e_gnt != 2'b00) begin
                check("mem_address", mem_address, e_addr);
                check("mem_data_in", mem_data_in, e_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0;
        tick();
        rst = 0;
    endtask

    task automatic wait_gnt(input int port, input int budget, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (((port == 0) ? gnt_0 : gnt_1) !== 1'b1 && n < budget);
        check(name, (port == 0) ? gnt_0 : gnt_1, 1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return 12'hFFF;
            2:       return AW'(12'h010 + $urandom_range(0, 7));
            default: return AW'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] seq [8];
        int rise [2];
        int nrise, busy_cycles;
        bit saw_busy, gnt_after;

        seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        @(negedge clk);

        // 1: p0 write then p1 read of the same address
        do_reset();
        req_0 = 1; we_0 = 1; addr_0 = 12'h123; wdata_0 = 8'hA5;
        wait_gnt(0, 10, "t1_gnt0");
        req_0 = 0; we_0 = 0;
        tick();
        req_1 = 1; we_1 = 0; addr_1 = 12'h123;
        tick();
        check("t1_gnt1_latency", gnt_1, 1);
        req_1 = 0;
        tick();
        check("t1_rvalid1", rvalid_1, 1);
        check("t1_rdata1", rdata_1, 8'hA5);
        $display("t1 write/read 0x123 rdata_1=%0h", rdata_1);

        // 2: both ports reading continuously alternate, port 0 first
        do_reset();
        req_0 = 1; we_0 = 0; addr_0 = 12'h123;
        req_1 = 1; we_1 = 0; addr_1 = 12'hFFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t2_grant_seq", {gnt_1, gnt_0}, seq[i]);
        end
        req_0 = 0; req_1 = 0;
        $display("t2 alternating grants done");

        // 3: idle bus refresh cadence
        do_reset();
        nrise = 0; busy_cycles = 0; rise[0] = 0; rise[1] = 0;
        for (int i = 1; i <= 140; i++) begin
            logic prev;
            prev = refresh_busy;
            tick();
            if (refresh_busy) busy_cycles++;
            if (refresh_busy && !prev && nrise < 2) begin
                rise[nrise] = i;
                nrise++;
            end
            if (i == 69) check("t3_count_after_first", refresh_count, 1);
        end
        check("t3_first_rise", rise[0], 65);
        check("t3_second_rise", rise[1], 129);
        check("t3_busy_cycles", busy_cycles, 8);
        check("t3_count_final", refresh_count, 2);
        $display("t3 refresh rises at %0d and %0d, count=%0d", rise[0], rise[1], refresh_count);

        // 4: held request through a refresh window
        do_reset();
        tick(50);
        req_0 = 1; we_0 = 0; addr_0 = 12'h010;
        saw_busy = 0; gnt_after = 0;
        for (int i = 51; i <= 100; i++) begin
            tick();
            if (refresh_busy) begin
                saw_busy = 1;
                check("t4_no_gnt_in_refresh", gnt_0, 0);
                check("t4_no_we_in_refresh", mem_we, 0);
            end else if (saw_busy && gnt_0) begin
                gnt_after = 1;
            end
        end
        req_0 = 0;
        check("t4_saw_refresh", saw_busy, 1);
        check("t4_gnt_after_refresh", gnt_after, 1);
        $display("t4 held request across refresh, gnt_after=%0d", gnt_after);

        // 5: interval wraps during a write access
        do_reset();
        tick(62);
        req_0 = 1; we_0 = 1; addr_0 = 12'h010; wdata_0 = 8'h3C;
        tick();
        check("t5_gnt0", gnt_0, 1);
        check("t5_mem_we", mem_we, 1);
        req_0 = 0; we_0 = 0;
        tick(2);
        check("t5_refresh_follows", refresh_busy, 1);
        tick(5);
        req_1 = 1; we_1 = 0; addr_1 = 12'h010;
        wait_gnt(1, 10, "t5_read_gnt");
        req_1 = 0;
        tick();
        check("t5_readback", rdata_1, 8'h3C);
        $display("t5 write across wrap, readback=%0h", rdata_1);

        // 6: reset during a read access
        do_reset();
        req_0 = 1; we_0 = 0; addr_0 = 12'h123;
        wait_gnt(0, 10, "t6_gnt0");
        rst = 1; req_0 = 0;
        tick();
        check("t6_rvalid0_abandoned", rvalid_0, 0);
        check("t6_outputs_zero",
              {gnt_0, gnt_1, rvalid_1, refresh_busy, mem_we, rdata_0, rdata_1, mem_address}, 0);
        rst = 0;
        req_0 = 1; req_1 = 1; we_1 = 0; addr_1 = 12'h010;
        tick();
        check("t6_first_after_reset", {gnt_1, gnt_0}, 2'b01);
        req_0 = 0; req_1 = 0;
        $display("t6 reset mid-read, first grant {g1,g0}=%b", {gnt_1, gnt_0});

        // random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1; req_0 = 0; req_1 = 0;
                continue;
            end
            if (req_0 && gnt_0) req_0 = 0;
            if (req_1 && gnt_1) req_1 = 0;
            if (!req_0 && $urandom_range(0, 9) < 4) begin
                req_0 = 1; we_0 = 1'($urandom_range(0, 1));
                addr_0 = rand_addr(); wdata_0 = DW'($urandom);
            end
            if (!req_1 && $urandom_range(0, 9) < 4) begin
                req_1 = 1; we_1 = 1'($urandom_range(0, 1));
                addr_1 = rand_addr(); wdata_1 = DW'($urandom);
            end
        end
        rst = 0; req_0 = 0; req_1 = 0;
        tick(4);
        $display("random traffic done, refresh_count=%0d", refresh_count);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
